sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: BASE_ADDR, 1024, byte address mapped to SRAM word 0.
REQ-002 Parameter: ACCESS_CYCLES, 6, cycles from request acceptance to ready (minimum 3).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: wr_en  in  1  store request from the MEM stage; held stable while ready=0.
REQ-006 Port: rd_en  in  1  load request from the MEM stage; held stable while ready=0.
REQ-007 Port: address  in  32  byte address (the ALU result).
REQ-008 Port: writeData  in  32  store value.
REQ-009 Port: readData  out  32  load result.
REQ-010 Port: ready  out  1  0 = access in progress; pipeline freeze = ~ready.
REQ-011 Port: SRAM_DQ  inout  16  SRAM data bus.
REQ-012 Port: SRAM_ADDR  out  18  SRAM half-word address.
REQ-013 Port: SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, active-low.

Function
REQ-014 States: IDLE, LO, HI, WAIT, DONE; a 3-bit cycle counter tracks elapsed cycles.
REQ-015 IDLE: ready = ~(rd_en | wr_en), combinational, so the freeze asserts in the request cycle.
REQ-016 IDLE with rd_en or wr_en: capture the request and go to LO.
REQ-017 Transitions: LO->HI->WAIT; WAIT holds until ACCESS_CYCLES-1 cycles after acceptance, then DONE.
REQ-018 DONE: ready=1 for exactly one cycle; next state is IDLE unconditionally.
REQ-019 A request present in DONE is not restarted; the pipeline advances at that edge.
REQ-020 Word index W = (address - BASE_ADDR)[18:2], modulo 2^17; address[1:0] is ignored.
REQ-021 SRAM_ADDR = {W,0} in LO and {W,1} in HI; it holds its last value otherwise.
REQ-022 Write, LO: SRAM_WE_N=0, SRAM_DQ driven with writeData[15:0].
REQ-023 Write, HI: SRAM_WE_N=0, SRAM_DQ driven with writeData[31:16].
REQ-024 Write: SRAM_DQ is high-Z in every state other than write LO and write HI.
REQ-025 Read, LO: SRAM_OE_N=0; readData[15:0] latched from SRAM_DQ at the end of LO.
REQ-026 Read, HI: SRAM_OE_N=0; readData[31:16] latched from SRAM_DQ at the end of HI.
REQ-027 readData holds its value until the next read completes.
REQ-028 SRAM_CE_N=0, SRAM_UB_N=0, SRAM_LB_N=0 whenever out of reset.
REQ-029 SRAM_WE_N=1 and SRAM_OE_N=1 in all states other than those stated above.
REQ-030 rd_en and wr_en both set: performed as a write.
REQ-031 Request latency is fixed at ACCESS_CYCLES: ready is low for ACCESS_CYCLES cycles, including the request cycle, and readData is valid when ready rises.

Reset
REQ-032 rst low forces, asynchronously: state IDLE, counter 0, readData 0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z.
REQ-033 Reset in mid-access abandons the access; no further SRAM strobe occurs.
REQ-034 After reset, ready follows REQ-015.

Structure
REQ-035 The shared package holds the state encoding, SRAM_BASE_ADDR=1024 and SRAM_ACCESS_CYCLES=6; the parameter defaults reference these.
REQ-036 No RTL sub-module.
REQ-037 The bench uses a behavioural 256Kx16 sram_model with zero-delay reads.

Verification
REQ-038 Reset: rst=0 mid-write (in HI) -> WE_N=1 immediately, DQ=Z, ready=1, readData=0.
REQ-039 Write then read: address=1024, data 0xDEADBEEF -> model[0]=0xBEEF, model[1]=0xDEAD; then a read -> readData=0xDEADBEEF when ready rises.
REQ-040 Latency: read of address 1032 -> ready low exactly 6 cycles; ready high 1 cycle in DONE; SRAM_ADDR 4 then 5.
REQ-041 Back-to-back requests: rd_en held continuously -> second access starts in the cycle after DONE; ready pattern 0,0,0,0,0,0,1 repeats.
REQ-042 Both enables: rd_en=wr_en=1, address 1028, data 0x12345678 -> model[2]=0x5678, model[3]=0x1234; readData unchanged.
REQ-043 Wrap and alignment: address 1027 -> word 0; address 1024+2^19 -> word 0.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit-to-16-bit SRAM bridge: state encoding,
// default memory map and access timing, and the word-index helper.
package sram_controller_pkg;

    localparam logic [31:0] SRAM_BASE_ADDR     = 32'd1024;
    localparam int unsigned SRAM_ACCESS_CYCLES = 32'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Word index relative to the SRAM base; the truncation gives the 2^17 wrap.
    function automatic logic [16:0] word_index(input logic [31:0] address,
                                               input logic [31:0] base);
        return 17'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then
// high half) and stretches the request to a fixed ACCESS_CYCLES latency.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = SRAM_BASE_ADDR,
    parameter int unsigned ACCESS_CYCLES = SRAM_ACCESS_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 32'd1);

    state_e      state_r;
    logic [2:0]  cnt_r;
    logic [16:0] word_r;
    logic        is_write_r;
    logic [15:0] wdata_hi_r;
    logic [15:0] rdata_lo_r;
    logic [15:0] rdata_hi_r;
    logic [31:0] rdata_r;
    logic [17:0] sram_addr_r;
    logic        we_n_r;
    logic        oe_n_r;
    logic        dq_oe_r;
    logic [15:0] dq_out_r;
    logic        req_s;
    logic        ready_s;
    logic [16:0] word_s;

    // Request decode; ready drops in the request cycle itself so the pipeline freezes at once
    always_comb begin
        req_s  = rd_en | wr_en;
        word_s = word_index(address, BASE_ADDR);
        case (state_r)
            ST_IDLE: ready_s = ~req_s;
            ST_DONE: ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Access sequencer with registered SRAM strobes, address and data bus control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            word_r      <= 17'd0;
            is_write_r  <= 1'b0;
            wdata_hi_r  <= 16'd0;
            rdata_lo_r  <= 16'd0;
            rdata_hi_r  <= 16'd0;
            rdata_r     <= 32'd0;
            sram_addr_r <= 18'd0;
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_r     <= ST_LO;
                        cnt_r       <= 3'd1;
                        word_r      <= word_s;
                        is_write_r  <= wr_en;
                        wdata_hi_r  <= writeData[31:16];
                        sram_addr_r <= {word_s, 1'b0};
                        we_n_r      <= ~wr_en;
                        oe_n_r      <= wr_en;
                        dq_oe_r     <= wr_en;
                        dq_out_r    <= writeData[15:0];
                    end else begin
                        cnt_r <= 3'd0;
                    end
                end
                ST_LO: begin
                    state_r     <= ST_HI;
                    cnt_r       <= cnt_r + 3'd1;
                    sram_addr_r <= {word_r, 1'b1};
                    dq_out_r    <= wdata_hi_r;
                    if (!is_write_r) begin
                        rdata_lo_r <= SRAM_DQ;
                    end
                end
                ST_HI: begin
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    dq_oe_r <= 1'b0;
                    cnt_r   <= cnt_r + 3'd1;
                    if (!is_write_r) begin
                        rdata_hi_r <= SRAM_DQ;
                    end
                    // With the minimum latency there is no WAIT stage at all
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                        if (!is_write_r) begin
                            rdata_r <= {SRAM_DQ, rdata_lo_r};
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                        if (!is_write_r) begin
                            rdata_r <= {rdata_hi_r, rdata_lo_r};
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    dq_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_s;
    assign readData  = rdata_r;
    assign SRAM_ADDR = sram_addr_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_OE_N = oe_n_r;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a 256Kx16 zero-delay SRAM device model,
// a per-cycle transaction-level reference model, and hand-computed checks.
module tb_sram_controller;

    localparam int          AC    = 6;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          WORDS = 262144;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    tri1  [15:0] sram_dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    logic [15:0] sram_mem [0:WORDS-1];
    logic [15:0] ref_mem  [0:WORDS-1];
    logic [17:0] addr_seen [0:7];
    int          checks;
    int          errors;

    sram_controller dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        logic [15:0] v;
        v = i[15:0];
        return v ^ 16'hA5C3;
    endfunction

    // SRAM device: zero-delay read while OE is low, write sampled at the clock edge
    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR] : 16'bz;

    initial begin
        for (int i = 0; i < WORDS; i++) sram_mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR] = sram_dq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one access = request cycle, AC-1 busy cycles, one done cycle
    task automatic model_loop();
        int          phase;
        logic [16:0] w;
        bit          wr;
        logic [31:0] wd;
        logic [31:0] pend;
        logic [31:0] exp_rd;
        bit          req;
        phase  = 0;
        w      = '0;
        wr     = 1'b0;
        wd     = '0;
        pend   = '0;
        exp_rd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase  = 0;
                exp_rd = '0;
            end else begin
                req = rd_en | wr_en;
                if (phase == AC && !wr) exp_rd = pend;
                chk("ready", ready, (phase == 0) ? !req : (phase == AC));
                chk("ce_ub_lb_n", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
                chk("readData", readData, exp_rd);
                if (phase == 1 || phase == 2) begin
                    chk("sram_addr", SRAM_ADDR, 2 * w + (phase - 1));
                    chk("we_n_active", SRAM_WE_N, !wr);
                    chk("oe_n_active", SRAM_OE_N, wr);
                    if (wr) chk("dq_write", sram_dq, (phase == 1) ? wd[15:0] : wd[31:16]);
                end else begin
                    chk("we_n_idle", SRAM_WE_N, 32'd1);
                    chk("oe_n_idle", SRAM_OE_N, 32'd1);
                    chk("dq_released", sram_dq, 32'h0000FFFF);
                end
                if (phase == 0) begin
                    if (req) begin
                        w     = 17'((address - BASE) >> 2);
                        wr    = wr_en;
                        wd    = writeData;
                        phase = 1;
                        if (wr) begin
                            ref_mem[2 * w]     = wd[15:0];
                            ref_mem[2 * w + 1] = wd[31:16];
                        end else begin
                            pend = {ref_mem[2 * w + 1], ref_mem[2 * w]};
                        end
                    end
                end else if (phase == AC) begin
                    phase = 0;
                end else begin
                    phase++;
                end
            end
        end
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        bit got;
        @(posedge clk);
        #1;
        rd_en     = rd;
        wr_en     = wr;
        address   = a;
        writeData = d;
        lat       = 0;
        got       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k < 8) addr_seen[k] = SRAM_ADDR;
            if (ready) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no ready within 20 cycles, expected ready after %0d", AC);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int   lat;
        logic [20:0] pattern;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        address   = 32'd0;
        writeData = 32'd0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);
        fork
            model_loop();
        join_none

        @(posedge clk);
        #1;
        chk("reset_ready", ready, 32'd1);
        chk("reset_we_n", SRAM_WE_N, 32'd1);
        chk("reset_oe_n", SRAM_OE_N, 32'd1);
        chk("reset_dq", sram_dq, 32'h0000FFFF);
        chk("reset_readData", readData, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
        chk("write_latency", lat, AC);
        chk("write_mem0", sram_mem[0], 32'h0000BEEF);
        chk("write_mem1", sram_mem[1], 32'h0000DEAD);

        do_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        chk("read_back", readData, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'd1032, 32'd0, lat);
        chk("read_latency", lat, AC);
        chk("read_addr_lo", addr_seen[1], 32'd4);
        chk("read_addr_hi", addr_seen[2], 32'd5);
        chk("read_1032", readData, 32'hA5C6A5C7);

        // rd_en held across three back-to-back accesses
        @(posedge clk);
        #1;
        rd_en   = 1'b1;
        address = 32'd1032;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            pattern[k] = ready;
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("b2b_ready_pattern", 32'(pattern), 32'(21'b100000010000001000000));

        do_req(1'b1, 1'b1, 32'd1028, 32'h12345678, lat);
        chk("both_mem2", sram_mem[2], 32'h00005678);
        chk("both_mem3", sram_mem[3], 32'h00001234);
        chk("both_readData_kept", readData, 32'hA5C6A5C7);

        do_req(1'b0, 1'b1, 32'd1027, 32'h0BADF00D, lat);
        chk("align_mem0", sram_mem[0], 32'h0000F00D);
        chk("align_mem1", sram_mem[1], 32'h00000BAD);
        do_req(1'b0, 1'b1, 32'd1024 + 32'd524288, 32'hCAFE1234, lat);
        chk("wrap_mem0", sram_mem[0], 32'h00001234);
        chk("wrap_mem1", sram_mem[1], 32'h0000CAFE);
        do_req(1'b1, 1'b0, 32'd1020, 32'd0, lat);
        chk("below_base_addr", addr_seen[1], 32'h0003FFFE);
        chk("below_base_read", readData, 32'h5A3C5A3D);

        // Reset while the high half of a write is on the bus
        @(posedge clk);
        #1;
        wr_en     = 1'b1;
        address   = 32'd1088;
        writeData = 32'h11112222;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("midreset_we_n", SRAM_WE_N, 32'd1);
        chk("midreset_oe_n", SRAM_OE_N, 32'd1);
        chk("midreset_dq", sram_dq, 32'h0000FFFF);
        chk("midreset_ready", ready, 32'd1);
        chk("midreset_readData", readData, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("midreset_hi_untouched", sram_mem[33], 32'h0000A5E2);

        do_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        chk("post_reset_read", readData, 32'hCAFE1234);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
